// File: rtl/seq_pkg.sv
// Shared definitions for the cycle sequencer: state encodings, latched flag layout
// and the default memory timeout.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } instr_flags_t;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 15;
  // Wide enough for the largest legal timeout (255).
  localparam int WAIT_CNT_W = 8;

  function automatic logic is_busy(input seq_state_e s);
    return !((s == S_IDLE) || (s == S_ERROR));
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-not-ready cycles; expired flags the cycle on which
// the count has reached TIMEOUT-1.
module mem_wait_timer
  import seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clock,
  input  logic resetN,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] r_count;

  // Clear wins so the count always starts from zero on MEMORY entry.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK) with a
// memory-wait timeout into a sticky ERROR state. Define SEQ_SINGLE_STEP_EN to add stepReq.
module cycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             stepReq,
`endif
  input  logic             memReadFlag,
  input  logic             memWriteFlag,
  input  logic             regWriteFlag,
  input  logic             memReady,
  output logic             fetchEn,
  output logic             decodeEn,
  output logic             execEn,
  output logic             pcEn,
  output logic             memReq,
  output logic             memWe,
  output logic             wbEn,
  output logic [2:0]       state,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] instrCount
);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  instr_flags_t     r_flags;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_start;
  logic             w_timer_clear;
  logic             w_timer_count;
  logic             w_timer_expired;

`ifdef SEQ_SINGLE_STEP_EN
  // A step starts only on a stepReq rising edge, so a held request runs one instruction.
  logic r_step_prev;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_step_prev <= 1'b0;
    end else begin
      r_step_prev <= stepReq;
    end
  end

  assign w_start = run | (stepReq & ~r_step_prev);
`else
  assign w_start = run;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_flags <= '0;
    end else if (r_state == S_DECODE) begin
      r_flags <= '{mem_read: memReadFlag, mem_write: memWriteFlag, reg_write: regWriteFlag};
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_instr_count <= '0;
    end else if (r_state == S_WRITEBACK) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  // Holding the timer clear outside MEMORY guarantees a fresh count on every entry.
  assign w_timer_clear = (r_state != S_MEMORY);
  assign w_timer_count = (r_state == S_MEMORY) && !memReady;

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clock    (clock),
    .resetN   (resetN),
    .clear    (w_timer_clear),
    .count_en (w_timer_count),
    .expired  (w_timer_expired)
  );

  always_comb begin
    w_state_next = r_state;
    fetchEn      = 1'b0;
    decodeEn     = 1'b0;
    execEn       = 1'b0;
    pcEn         = 1'b0;
    memReq       = 1'b0;
    memWe        = 1'b0;
    wbEn         = 1'b0;
    error        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        fetchEn      = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        decodeEn     = 1'b1;
        w_state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        execEn       = 1'b1;
        w_state_next = (r_flags.mem_read || r_flags.mem_write) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        memReq = 1'b1;
        memWe  = r_flags.mem_write;
        // A ready on the final allowed cycle still completes the access.
        if (memReady) begin
          w_state_next = S_WRITEBACK;
        end else if (w_timer_expired) begin
          w_state_next = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        pcEn         = 1'b1;
        wbEn         = r_flags.reg_write;
        w_state_next = run ? S_FETCH : S_IDLE;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        w_state_next = S_ERROR;
      end
    endcase
  end

  assign state      = r_state;
  assign busy       = is_busy(r_state);
  assign instrCount = r_instr_count;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer (MEM_TIMEOUT=4, CNT_W=4) using randomized
// instructions against a per-instruction state-sequence model.
module tb_cycle_sequencer;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clock = 1'b0;
  logic          resetN;
  logic          run;
  logic          memReadFlag, memWriteFlag, regWriteFlag, memReady;
`ifdef SEQ_SINGLE_STEP_EN
  logic          stepReq;
`endif
  logic          fetchEn, decodeEn, execEn, pcEn, memReq, memWe, wbEn, busy, error;
  logic [2:0]    state;
  logic [CW-1:0] instrCount;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;
  logic [2:0] obs_trace[$];
  logic [2:0] exp_trace[$];

  always #5 clock = ~clock;

  cycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock        (clock),
    .resetN       (resetN),
    .run          (run),
`ifdef SEQ_SINGLE_STEP_EN
    .stepReq      (stepReq),
`endif
    .memReadFlag  (memReadFlag),
    .memWriteFlag (memWriteFlag),
    .regWriteFlag (regWriteFlag),
    .memReady     (memReady),
    .fetchEn      (fetchEn),
    .decodeEn     (decodeEn),
    .execEn       (execEn),
    .pcEn         (pcEn),
    .memReq       (memReq),
    .memWe        (memWe),
    .wbEn         (wbEn),
    .state        (state),
    .busy         (busy),
    .error        (error),
    .instrCount   (instrCount)
  );

  // Expected per-cycle state walk for one instruction: 1=F 2=D 3=E 4=M 5=WB 6=ERR.
  function automatic void model_trace(input logic rd, input logic wr, input int w);
    exp_trace.delete();
    exp_trace.push_back(3'd1);
    exp_trace.push_back(3'd2);
    exp_trace.push_back(3'd3);
    if (rd | wr) begin
      for (int i = 0; i < w + 1 && i < TMO; i++) exp_trace.push_back(3'd4);
      exp_trace.push_back((w >= TMO) ? 3'd6 : 3'd5);
    end else begin
      exp_trace.push_back(3'd5);
    end
  endfunction

  function automatic int trace_diff();
    int n;
    n = (obs_trace.size() < exp_trace.size()) ? obs_trace.size() : exp_trace.size();
    for (int i = 0; i < n; i++) if (obs_trace[i] !== exp_trace[i]) return i;
    if (obs_trace.size() != exp_trace.size()) return n;
    return -1;
  endfunction

  task automatic do_reset();
    run = 1'b0; memReadFlag = 1'b0; memWriteFlag = 1'b0; regWriteFlag = 1'b0; memReady = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    stepReq = 1'b0;
`endif
    @(negedge clock); resetN = 1'b0;
    @(negedge clock); resetN = 1'b1;
    exp_count = 0;
  endtask

  // Drives one instruction from IDLE (or WRITEBACK) and records what the DUT did.
  task automatic exec_instr(input logic rd, input logic wr, input logic rw, input int w,
                            output int cycles, output int mreq_cnt, output logic we_seen,
                            output logic we_stray, output logic wb_seen, output logic pc_seen,
                            output int en_bad, output logic hung);
    int k;
    logic [5:0] exp_en;
    obs_trace.delete();
    cycles = 0; mreq_cnt = 0; we_seen = 0; we_stray = 0; wb_seen = 0; pc_seen = 0;
    en_bad = 0; hung = 1; k = 0;
    run = 1'b1; memReadFlag = rd; memWriteFlag = wr; regWriteFlag = rw; memReady = 1'($urandom);
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      cycles++;
      obs_trace.push_back(state);
      exp_en = 6'b0;
      case (state)
        3'd1: exp_en = 6'b110000;
        3'd2: exp_en = 6'b101000;
        3'd3: exp_en = 6'b100100;
        3'd4: exp_en = 6'b100010;
        3'd5: exp_en = 6'b100001;
        default: exp_en = 6'b0;
      endcase
      if ({busy, fetchEn, decodeEn, execEn, memReq, pcEn} !== exp_en) en_bad++;
      if (state == 3'd4) begin
        mreq_cnt++;
        we_seen = we_seen | memWe;
        memReady = (k >= w);
        k++;
      end else begin
        we_stray = we_stray | memWe;
        memReady = 1'($urandom);
      end
      if (state == 3'd1) run = 1'($urandom);
      if (state == 3'd3) begin
        memReadFlag = 1'($urandom); memWriteFlag = 1'($urandom); regWriteFlag = 1'($urandom);
      end
      if (state == 3'd5) begin
        wb_seen = wbEn; pc_seen = pcEn; run = 1'b0; hung = 0;
        break;
      end
      if (state == 3'd6) begin
        hung = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    #2 resetN = 1'b0;
    run = 1'b0; memReadFlag = 1'b0; memWriteFlag = 1'b0; regWriteFlag = 1'b0; memReady = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    stepReq = 1'b0;
`endif
    #1;
    n_cmp++;
    if (state !== 3'd0 || instrCount !== 4'd0 || error !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got state=%0d cnt=%0d err=%0b busy=%0b, required 0/0/0/0",
               state, instrCount, error, busy);
    end
    n_cmp++;
    if ({fetchEn, decodeEn, execEn, pcEn, memReq, memWe, wbEn} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_enables: got %b, required 0000000",
               {fetchEn, decodeEn, execEn, pcEn, memReq, memWe, wbEn});
    end
    @(negedge clock); resetN = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (state !== 3'd0) begin
      n_bad++;
      $display("FAIL idle_hold: got state=%0d, required 0 with run=0", state);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    int cyc, mrc, enb, d;
    logic wes, wst, wbs, pcs, hung;
    model_trace(1'b0, 1'b0, 0);
    exec_instr(1'b0, 1'b0, 1'b1, 0, cyc, mrc, wes, wst, wbs, pcs, enb, hung);
    d = trace_diff();
    n_cmp++;
    if (d != -1 || hung || cyc != 4) begin
      n_bad++;
      $display("FAIL alu_trace: got len=%0d cycles=%0d diff@%0d, required len=%0d cycles=4",
               obs_trace.size(), cyc, d, exp_trace.size());
    end
    n_cmp++;
    if (wbs !== 1'b1 || pcs !== 1'b1 || enb != 0) begin
      n_bad++;
      $display("FAIL alu_wb: got wbEn=%0b pcEn=%0b enable_errors=%0d, required 1/1/0", wbs, pcs, enb);
    end
    @(posedge clock); #1;
    exp_count = (exp_count + 1) % 16;
    n_cmp++;
    if (instrCount !== 4'd1 || state !== 3'd0) begin
      n_bad++;
      $display("FAIL alu_retire: got cnt=%0d state=%0d, required 1/0", instrCount, state);
    end
    $display("test_alu: %0d cycles, count=%0d", cyc, instrCount);
  endtask

  task automatic test_load();
    int cyc, mrc, enb, d;
    logic wes, wst, wbs, pcs, hung;
    model_trace(1'b1, 1'b0, 2);
    exec_instr(1'b1, 1'b0, 1'b1, 2, cyc, mrc, wes, wst, wbs, pcs, enb, hung);
    d = trace_diff();
    n_cmp++;
    if (d != -1 || hung || cyc != 7) begin
      n_bad++;
      $display("FAIL load_latency: got cycles=%0d diff@%0d, required 7", cyc, d);
    end
    n_cmp++;
    if (mrc != 3 || wes !== 1'b0 || wst !== 1'b0 || enb != 0) begin
      n_bad++;
      $display("FAIL load_mem: got memReq_cycles=%0d memWe=%0b stray=%0b en_err=%0d, required 3/0/0/0",
               mrc, wes, wst, enb);
    end
    exp_count = (exp_count + 1) % 16;
    $display("test_load: %0d cycles, %0d memReq cycles", cyc, mrc);
  endtask

  task automatic test_timeout_win();
    int cyc, mrc, enb, d;
    logic wes, wst, wbs, pcs, hung;
    model_trace(1'b1, 1'b1, TMO - 1);
    exec_instr(1'b1, 1'b1, 1'b0, TMO - 1, cyc, mrc, wes, wst, wbs, pcs, enb, hung);
    d = trace_diff();
    n_cmp++;
    if (d != -1 || hung || cyc != 5 + TMO - 1 || wbs !== 1'b0 || wes !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_wins: got cycles=%0d diff@%0d wbEn=%0b memWe=%0b, required %0d/-1/0/1",
               cyc, d, wbs, wes, 5 + TMO - 1);
    end
    exp_count = (exp_count + 1) % 16;
    $display("test_timeout_win: %0d cycles", cyc);
  endtask

  task automatic test_random();
    int cyc, mrc, enb, d, w;
    logic wes, wst, wbs, pcs, hung, rd, wr, rw;
    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom); wr = 1'($urandom); rw = 1'($urandom);
      w = $urandom_range(0, TMO - 1);
      model_trace(rd, wr, w);
      exec_instr(rd, wr, rw, w, cyc, mrc, wes, wst, wbs, pcs, enb, hung);
      d = trace_diff();
      n_cmp++;
      if (d != -1 || hung || cyc != ((rd | wr) ? 5 + w : 4)) begin
        n_bad++;
        $display("FAIL random[%0d]_trace: got len=%0d cycles=%0d diff@%0d, required len=%0d (rd=%0b wr=%0b w=%0d)",
                 i, obs_trace.size(), cyc, d, exp_trace.size(), rd, wr, w);
      end
      n_cmp++;
      if (wes !== wr || wst !== 1'b0 || wbs !== rw || pcs !== 1'b1 || enb != 0) begin
        n_bad++;
        $display("FAIL random[%0d]_outputs: got memWe=%0b stray=%0b wbEn=%0b pcEn=%0b en_err=%0d, required %0b/0/%0b/1/0",
                 i, wes, wst, wbs, pcs, enb, wr, rw);
      end
      n_cmp++;
      if (instrCount !== 4'(exp_count)) begin
        n_bad++;
        $display("FAIL random[%0d]_count: got %0d, required %0d", i, instrCount, exp_count);
      end
      exp_count = (exp_count + 1) % 16;
      $display("random[%0d] rd=%0b wr=%0b rw=%0b w=%0d cycles=%0d", i, rd, wr, rw, w, cyc);
    end
  endtask

  task automatic test_reset_mid_memory();
    logic reached;
    reached = 1'b0;
    run = 1'b1; memReadFlag = 1'b1; memWriteFlag = 1'b1; regWriteFlag = 1'b1; memReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      run = 1'b0;
      if (state == 3'd4) begin
        reached = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!reached || memReq !== 1'b1) begin
      n_bad++;
      $display("FAIL reach_memory: got state=%0d memReq=%0b, required 4/1", state, memReq);
    end
    #2 resetN = 1'b0;
    #1;
    n_cmp++;
    if (state !== 3'd0 || memReq !== 1'b0 || instrCount !== 4'd0 || busy !== 1'b0 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got state=%0d memReq=%0b cnt=%0d busy=%0b err=%0b, required 0/0/0/0/0",
               state, memReq, instrCount, busy, error);
    end
    memReady = 1'b0;
    @(negedge clock); resetN = 1'b1;
    exp_count = 0;
    $display("test_reset_mid_memory done");
  endtask

  task automatic test_wrap();
    int cyc, mrc, enb;
    logic wes, wst, wbs, pcs, hung;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exec_instr(1'b0, 1'b0, 1'($urandom), 0, cyc, mrc, wes, wst, wbs, pcs, enb, hung);
      n_cmp++;
      if (hung || instrCount !== 4'(exp_count)) begin
        n_bad++;
        $display("FAIL wrap[%0d]_count: got %0d, required %0d", i, instrCount, exp_count);
      end
      exp_count = (exp_count + 1) % 16;
      $display("wrap[%0d] count=%0d", i, instrCount);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (instrCount !== 4'd0 || exp_count != 0) begin
      n_bad++;
      $display("FAIL wrap_zero: got %0d, required 0", instrCount);
    end
  endtask

  task automatic test_timeout();
    int cyc, mrc, enb, d, stuck_bad;
    logic wes, wst, wbs, pcs, hung;
    model_trace(1'b0, 1'b1, 50);
    exec_instr(1'b0, 1'b1, 1'b1, 50, cyc, mrc, wes, wst, wbs, pcs, enb, hung);
    d = trace_diff();
    n_cmp++;
    if (d != -1 || hung || cyc != 4 + TMO || mrc != TMO) begin
      n_bad++;
      $display("FAIL timeout_error: got cycles=%0d memReq_cycles=%0d diff@%0d, required %0d/%0d",
               cyc, mrc, d, 4 + TMO, TMO);
    end
    stuck_bad = 0;
    for (int c = 0; c < 8; c++) begin
      run = 1'($urandom); memReady = 1'($urandom);
      @(posedge clock); #1;
      if (state !== 3'd6 || error !== 1'b1 || busy !== 1'b0 ||
          {fetchEn, decodeEn, execEn, pcEn, memReq, memWe, wbEn} !== 7'b0) stuck_bad++;
    end
    n_cmp++;
    if (stuck_bad != 0) begin
      n_bad++;
      $display("FAIL error_sticky: got %0d bad cycles, required 0", stuck_bad);
    end
    do_reset();
    #1;
    n_cmp++;
    if (error !== 1'b0 || state !== 3'd0) begin
      n_bad++;
      $display("FAIL error_clear: got err=%0b state=%0d, required 0/0", error, state);
    end
    $display("test_timeout: error after %0d memory cycles", mrc);
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_step();
    int retired, idle_bad;
    retired = 0; idle_bad = 0;
    run = 1'b0; memReadFlag = 1'b0; memWriteFlag = 1'b0; regWriteFlag = 1'b1;
    stepReq = 1'b1;
    @(posedge clock); #1;
    stepReq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (state == 3'd5) retired++;
      @(posedge clock); #1;
    end
    for (int c = 0; c < 4; c++) begin
      if (state !== 3'd0) idle_bad++;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (retired != 1 || idle_bad != 0 || instrCount !== 4'(exp_count + 1)) begin
      n_bad++;
      $display("FAIL single_step: got retired=%0d idle_errors=%0d cnt=%0d, required 1/0/%0d",
               retired, idle_bad, instrCount, exp_count + 1);
    end
    exp_count = (exp_count + 1) % 16;
    $display("test_step: retired=%0d", retired);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_timeout_win();
    test_random();
    test_reset_mid_memory();
    test_wrap();
    test_timeout();
`ifdef SEQ_SINGLE_STEP_EN
    test_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
- REQ-001: Parameter MEM_TIMEOUT, default 15; the count of consecutive memory-not-ready cycles that forces ERROR; legal range 1..255.
- REQ-002: Parameter CNT_W, default 32; width of the retired-instruction counter.
- REQ-003: clock  in  1  single processor clock; all state updates on its rising edge.
- REQ-004: resetN  in  1  asynchronous, active-low reset.
- REQ-005: run  in  1  enables continuous instruction sequencing.
- REQ-006: memReadFlag / memWriteFlag / regWriteFlag  in  1 each  controller flags for the current instruction.
- REQ-007: memReady  in  1  data cache access-complete handshake.
- REQ-008: fetchEn / decodeEn / execEn / pcEn  out  1 each  stage enables for instruction cache, controller, ALU and PC.
- REQ-009: memReq  out  1  data cache request; memWe  out  1  write qualifier.
- REQ-010: wbEn  out  1  register-file write enable.
- REQ-011: state  out  3  current state encoding; busy  out  1  high in any state other than IDLE and ERROR; error  out  1  sticky fault flag.
- REQ-012: instrCount  out  CNT_W  retired-instruction count.

Function
- REQ-013: States SHALL be IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and ERROR, held in one registered state variable.
- REQ-014: Outputs SHALL be Moore-decoded from state, with each enable high for exactly the cycles spent in its state.
- REQ-015: IDLE SHALL go to FETCH when run=1 and otherwise hold; FETCH -> DECODE and DECODE -> EXECUTE unconditionally.
- REQ-016: Flags SHALL be sampled into internal latches at the end of DECODE and held constant until the next DECODE.
- REQ-017: EXECUTE SHALL go to MEMORY if the latched memRead or memWrite is set, else to WRITEBACK.
- REQ-018: In MEMORY: memReq=1 and memWe=latched memWrite; if both memory flags are set, the access is a write (memWe=1).
- REQ-019: MEMORY SHALL go to WRITEBACK on the first cycle memReady=1.
- REQ-020: The wait counter SHALL clear on entering MEMORY and increment on each MEMORY cycle with memReady=0.
- REQ-021: On the MEMORY cycle where memReady=0 and the wait count equals MEM_TIMEOUT-1, the block SHALL enter ERROR; memReady=1 on that cycle SHALL win.
- REQ-022: In WRITEBACK: pcEn=1, wbEn=latched regWrite, and instrCount increments modulo 2^CNT_W.
- REQ-023: WRITEBACK SHALL go to FETCH if run=1, else to IDLE; a run deassertion mid-instruction completes the instruction first.
- REQ-024: ERROR SHALL hold all enables low and error=1 until reset; run has no effect there.
- REQ-025: Latency SHALL be 4 cycles per non-memory instruction and 5+W cycles per memory instruction, where W is the number of not-ready cycles.

Reset
- REQ-026: resetN=0 SHALL immediately force IDLE, all enables 0, error=0, instrCount=0, wait counter=0 and flag latches=0, including mid-operation.
- REQ-027: The first transition after deassertion SHALL occur on a rising clock edge with resetN=1.

Configuration
- REQ-028: Macro SEQ_SINGLE_STEP_EN defined: the block SHALL add input stepReq (1 bit).
- REQ-029: With SEQ_SINGLE_STEP_EN, IDLE with run=0 and stepReq=1 SHALL run exactly one instruction and then return to IDLE regardless of stepReq.
- REQ-030: With SEQ_SINGLE_STEP_EN, run=1 SHALL take priority over stepReq.
- REQ-031: Macro SEQ_SINGLE_STEP_EN undefined: the stepReq port SHALL be absent and only run SHALL start sequencing.

Structure
- REQ-032: State encodings (IDLE=0 ... ERROR=6) and the default MEM_TIMEOUT SHALL reside in shared package seq_pkg.
- REQ-033: The wait counter and its timeout compare SHALL be sub-module mem_wait_timer (ports: clock, resetN, clear, count_en, expired).

Verification
- REQ-034: Bench SHALL apply run=1 at cycle 0 with an ALU instruction (no mem flags, regWrite=1) and check FETCH@1, DECODE@2, EXECUTE@3, WRITEBACK@4 with wbEn=1, then instrCount=1.
- REQ-035: Bench SHALL issue a load (memRead=1) with memReady low for 2 cycles then high, and check memReq high 3 cycles, memWe=0, and 7 cycles to retire.
- REQ-036: Bench SHALL set MEM_TIMEOUT=4 and hold memReady=0, and check ERROR after 4 MEMORY cycles with error=1 persisting; memReady=1 on the 4th cycle instead SHALL give WRITEBACK.
- REQ-037: Bench SHALL set CNT_W=4 and retire 16 instructions, and check instrCount wraps 15 -> 0.
- REQ-038: Bench SHALL assert resetN=0 mid-MEMORY, and check state=IDLE, memReq=0 and instrCount=0 with no clock edge.
- REQ-039: Bench SHALL, with SEQ_SINGLE_STEP_EN, pulse stepReq for 1 cycle with run=0, and check exactly one instruction retires and the block returns to IDLE.
